ps2_tx_bank: RTL and testbench

Parametrised bank of PS/2 device-side transmitters, each with its own byte FIFO, sharing one PS/2 bit-clock divider. It sits between the IO-controller SPI command decoder in the `clk_sys` domain and the core's PS/2 keyboard, mouse or extra-device inputs. It generalises the fixed keyboard and mouse transmitter pair to N channels with configurable FIFO depth. Over the fixed pair it adds sticky overflow reporting, full-depth FIFOs, status outputs and optional host-inhibit handling.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_tx_channel.sv | 189 ++++++++++++++++++
 rtl/ps2_tx_bank.sv | 79 +++++++
 tb/tb_ps2_tx_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 transmit bank.
// Holds the frame FSM state enum, frame tick count and index width helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIT,
        PARITY,
        STOP,
        DONE
    } ps2_state_e;

    // start + 8 data + parity + stop + the DONE tick that pops the FIFO
    localparam int PS2_FRAME_TICKS = 12;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_tx_channel.sv
// ps2_tx_channel: one PS/2 device-side transmitter with its own byte FIFO.
// Ports: i_clk/i_rst clock and async reset; i_tick/i_phase from the shared
//   divider; i_wr/i_wr_data queue a byte; i_clr_ovf clears the sticky flag;
//   i_ps2_clk sensed line clock (host inhibit, only with PS2_INHIBIT_EN);
//   o_full/o_empty/o_overflow/o_busy status; o_ps2_clk/o_ps2_data line out.
// Optional feature macro: PS2_INHIBIT_EN.
module ps2_tx_channel
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_phase,
    input  logic       i_wr,
    input  logic [7:0] i_wr_data,
    input  logic       i_clr_ovf,
    input  logic       i_ps2_clk,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow,
    output logic       o_busy,
    output logic       o_ps2_clk,
    output logic       o_ps2_data
);

    localparam int DEPTH = 2 ** FIFO_BITS;
    localparam int PTR_W = FIFO_BITS + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_ovf;

    ps2_state_e       r_state;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_par;
    logic             r_data;

    ps2_state_e       w_state_nx;
    logic [2:0]       w_idx_nx;
    logic [7:0]       w_shift_nx;
    logic             w_par_nx;
    logic             w_data_nx;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_abort;
    logic             w_line_ok;
    logic [7:0]       w_head;

    // extra MSB on each pointer tells a full FIFO from an empty one
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_BITS] != r_rptr[FIFO_BITS]) &&
                     (r_wptr[FIFO_BITS-1:0] == r_rptr[FIFO_BITS-1:0]);
    assign w_push  = i_wr && !w_full;
    assign w_drop  = i_wr && w_full;
    assign w_head  = r_mem[r_rptr[FIFO_BITS-1:0]];

`ifdef PS2_INHIBIT_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_ps2_clk};
        end
    end

    // host holding the clock low while we drive it high means inhibit
    assign w_line_ok = r_sync[1];
    assign w_abort   = i_phase && !r_sync[1] &&
                       (r_state == BIT || r_state == PARITY ||
                        r_state == STOP);
`else
    logic w_unused_ps2_clk;

    assign w_unused_ps2_clk = i_ps2_clk;
    assign w_line_ok        = 1'b1;
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_BITS-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            // a drop wins over a coincident clear
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_data  <= w_data_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_data_nx  = r_data;
        w_pop      = 1'b0;
        if (w_abort) begin
            // byte stays at the FIFO head and is resent from scratch
            w_state_nx = IDLE;
            w_data_nx  = 1'b1;
        end else if (i_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty && w_line_ok) begin
                        w_shift_nx = w_head;
                        w_par_nx   = 1'b1;
                        w_data_nx  = 1'b0;
                        w_idx_nx   = '0;
                        w_state_nx = BIT;
                    end
                end
                BIT: begin
                    w_data_nx  = r_shift[0];
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_par_nx   = r_par ^ r_shift[0];
                    if (r_idx == 3'd7) begin
                        w_state_nx = PARITY;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
                PARITY: begin
                    w_data_nx  = r_par;
                    w_state_nx = STOP;
                end
                STOP: begin
                    w_data_nx  = 1'b1;
                    w_state_nx = DONE;
                end
                DONE: begin
                    w_pop      = 1'b1;
                    w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_ovf;
    assign o_busy     = (r_state != IDLE);
    assign o_ps2_clk  = i_phase || (r_state == IDLE);
    assign o_ps2_data = r_data;

endmodule

// File: rtl/ps2_tx_bank.sv
// ps2_tx_bank: CHANNELS PS/2 transmitters sharing one bit-clock divider.
// Ports: clk_sys/reset clock and async reset; wr_strobe/wr_ch/wr_data queue
//   a byte; clr_overflow per-channel flag clear; fifo_full/fifo_empty/
//   overflow/busy status; ps2_clk_out/ps2_data_out lines to the core;
//   ps2_clk_in sensed line clock. Optional feature macro: PS2_INHIBIT_EN.
module ps2_tx_bank
    import ps2_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 1100
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic                            wr_strobe,
    input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
    input  logic [7:0]                      wr_data,
    input  logic [CHANNELS-1:0]             clr_overflow,
    output logic [CHANNELS-1:0]             fifo_full,
    output logic [CHANNELS-1:0]             fifo_empty,
    output logic [CHANNELS-1:0]             overflow,
    output logic [CHANNELS-1:0]             busy,
    output logic [CHANNELS-1:0]             ps2_clk_out,
    output logic [CHANNELS-1:0]             ps2_data_out,
    input  logic [CHANNELS-1:0]             ps2_clk_in
);

    localparam int DIV_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

    logic [DIV_W-1:0]    r_div;
    logic                r_phase;
    logic                r_phase_d;
    logic                w_tick;
    logic [CHANNELS-1:0] w_wr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_phase   <= 1'b0;
            r_phase_d <= 1'b0;
        end else begin
            r_phase_d <= r_phase;
            if (r_div == DIV_W'(PS2DIV)) begin
                r_div   <= '0;
                r_phase <= !r_phase;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // fires the cycle after the phase rises, so data moves during clk high
    assign w_tick = r_phase && !r_phase_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // out-of-range channel numbers never match and are dropped silently
        assign w_wr[g] = wr_strobe && (int'(wr_ch) == g);

        ps2_tx_channel #(
            .FIFO_BITS (FIFO_BITS)
        ) u_ch (
            .i_clk      (clk_sys),
            .i_rst      (reset),
            .i_tick     (w_tick),
            .i_phase    (r_phase),
            .i_wr       (w_wr[g]),
            .i_wr_data  (wr_data),
            .i_clr_ovf  (clr_overflow[g]),
            .i_ps2_clk  (ps2_clk_in[g]),
            .o_full     (fifo_full[g]),
            .o_empty    (fifo_empty[g]),
            .o_overflow (overflow[g]),
            .o_busy     (busy[g]),
            .o_ps2_clk  (ps2_clk_out[g]),
            .o_ps2_data (ps2_data_out[g])
        );
    end

endmodule

// File: tb/tb_ps2_tx_bank.sv
// tb_ps2_tx_bank: directed bench for ps2_tx_bank with a frame-level model.
// Define PS2_INHIBIT_EN for both bench and RTL to exercise host inhibit.
module tb_ps2_tx_bank;

    localparam int CH    = 3;
    localparam int FB    = 2;
    localparam int DIV   = 3;
    localparam int DEPTH = 4;
    localparam int HP    = DIV + 1;
`ifdef PS2_INHIBIT_EN
    localparam bit INH = 1'b1;
`else
    localparam bit INH = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          wr_strobe = 1'b0;
    logic [1:0]    wr_ch = 2'd0;
    logic [7:0]    wr_data = 8'h00;
    logic [CH-1:0] clr_overflow = '0;
    logic [CH-1:0] ps2_clk_in = '1;
    logic [CH-1:0] fifo_full;
    logic [CH-1:0] fifo_empty;
    logic [CH-1:0] overflow;
    logic [CH-1:0] busy;
    logic [CH-1:0] ps2_clk_out;
    logic [CH-1:0] ps2_data_out;

    ps2_tx_bank #(
        .CHANNELS  (CH),
        .FIFO_BITS (FB),
        .PS2DIV    (DIV)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr_strobe    (wr_strobe),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow),
        .busy         (busy),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .ps2_clk_in   (ps2_clk_in)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as count+head, frame as a tick index k into 11 line bits
    // (k=0 idle, 1..10 bits on the line, 11 the closing pop tick).
    logic [7:0]  m_mem [CH][DEPTH];
    int          m_cnt [CH];
    int          m_head [CH];
    int          m_k [CH];
    logic [10:0] m_frame [CH];
    logic        m_data [CH];
    logic        m_ovf [CH];
    logic [1:0]  m_sync [CH];
    int          m_n;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_n = 0;
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_head[c] = 0; m_k[c] = 0;
                m_data[c] = 1'b1; m_ovf[c] = 1'b0; m_sync[c] = 2'b11;
                m_frame[c] = '1;
            end
        end else begin
            bit pre_ph, prev_ph, tick;
            pre_ph  = ((m_n / HP) % 2) == 1;
            prev_ph = (m_n > 0) && (((m_n - 1) / HP) % 2 == 1);
            tick    = pre_ph && !prev_ph;
            for (int c = 0; c < CH; c++) begin
                int  pre_cnt;
                bit  pop, hit, abort, ok;
                pre_cnt = m_cnt[c];
                pop     = 0;
                abort   = INH && m_k[c] >= 1 && m_k[c] <= 10 &&
                          pre_ph && !m_sync[c][1];
                ok      = !INH || m_sync[c][1];
                if (abort) begin
                    m_k[c] = 0;
                    m_data[c] = 1'b1;
                end else if (tick) begin
                    if (m_k[c] == 0) begin
                        if (pre_cnt > 0 && ok) begin
                            m_frame[c] = frame_of(m_mem[c][m_head[c]]);
                            m_data[c] = m_frame[c][0];
                            m_k[c] = 1;
                        end
                    end else if (m_k[c] <= 10) begin
                        m_data[c] = m_frame[c][m_k[c]];
                        m_k[c]++;
                    end else begin
                        pop = 1;
                        m_k[c] = 0;
                    end
                end
                hit = wr_strobe && (int'(wr_ch) == c);
                if (hit && pre_cnt < DEPTH) begin
                    m_mem[c][(m_head[c] + m_cnt[c]) % DEPTH] = wr_data;
                    m_cnt[c]++;
                end
                if (hit && pre_cnt == DEPTH) m_ovf[c] = 1'b1;
                else if (clr_overflow[c]) m_ovf[c] = 1'b0;
                if (pop) begin
                    m_head[c] = (m_head[c] + 1) % DEPTH;
                    m_cnt[c]--;
                end
                m_sync[c] = {m_sync[c][0], ps2_clk_in[c]};
            end
            m_n++;
        end
    end

    always @(negedge clk_sys) begin
        logic ph;
        ph = ((m_n / HP) % 2) == 1;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("cycle ch%0d {busy,ovf,full,empty,clk,data}", c),
                  {26'd0, busy[c], overflow[c], fifo_full[c], fifo_empty[c],
                   ps2_clk_out[c], ps2_data_out[c]},
                  {26'd0, m_k[c] != 0, m_ovf[c], m_cnt[c] == DEPTH,
                   m_cnt[c] == 0, ph || (m_k[c] == 0), m_data[c]});
        end
    end

    task automatic wr(input int ch, input logic [7:0] d);
        @(negedge clk_sys);
        wr_strobe = 1'b1; wr_ch = 2'(ch); wr_data = d;
        @(negedge clk_sys);
        wr_strobe = 1'b0;
    endtask

    // collect data bits at n falling edges of ps2_clk_out[ch]
    task automatic capture(input int ch, input int n,
                           output logic [10:0] bits, output int got);
        logic prev;
        bits = '0;
        got  = 0;
        prev = ps2_clk_out[ch];
        for (int i = 0; i < 400 && got < n; i++) begin
            @(negedge clk_sys);
            if (prev && !ps2_clk_out[ch]) begin
                bits[got] = ps2_data_out[ch];
                got++;
            end
            prev = ps2_clk_out[ch];
        end
    endtask

    task automatic wait_idle(input int ch);
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (!busy[ch] && fifo_empty[ch]) break;
        end
        check($sformatf("idle wait ch%0d", ch), 32'(i < 1000), 32'd1);
    endtask

    initial begin
        logic [10:0] bits;
        int          got;

        repeat (3) @(negedge clk_sys);
        check("rst clk_out", 32'(ps2_clk_out), 32'b111);
        check("rst data_out", 32'(ps2_data_out), 32'b111);
        check("rst empty", 32'(fifo_empty), 32'b111);
        check("rst full", 32'(fifo_full), 32'b000);
        check("rst overflow", 32'(overflow), 32'b000);
        check("rst busy", 32'(busy), 32'b000);
        reset = 1'b0;

        wr(1, 8'hAA);
        capture(1, 11, bits, got);
        check("AA edges", 32'(got), 32'd11);
        check("AA frame", 32'(bits), 32'b111_0101_0100);
        wait_idle(1);

        @(negedge clk_sys);
        wr_strobe = 1'b1; wr_ch = 2'd0; wr_data = 8'h00;
        @(negedge clk_sys);
        wr_data = 8'hFF;
        @(negedge clk_sys);
        wr_strobe = 1'b0;
        capture(0, 11, bits, got);
        check("00 frame", 32'(bits), 32'b110_0000_0000);
        capture(0, 11, bits, got);
        check("FF frame", 32'(bits), 32'b111_1111_1110);
        wait_idle(0);
        check("ch0 empty after pair", 32'(fifo_empty[0]), 32'd1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            wr_strobe = 1'b1; wr_ch = 2'd2; wr_data = 8'(8'h11 * (i + 1));
        end
        @(negedge clk_sys);
        check("ch2 full after 4", 32'(fifo_full[2]), 32'd1);
        check("ch2 no ovf yet", 32'(overflow[2]), 32'd0);
        wr_data = 8'h55;
        @(negedge clk_sys);
        check("ch2 ovf after drop", 32'(overflow[2]), 32'd1);
        wr_data = 8'h66; clr_overflow = 3'b100;
        @(negedge clk_sys);
        check("ovf set beats clear", 32'(overflow[2]), 32'd1);
        wr_strobe = 1'b0;
        @(negedge clk_sys);
        check("ovf cleared", 32'(overflow[2]), 32'd0);
        clr_overflow = '0;
        wr_strobe = 1'b1; wr_ch = 2'd3; wr_data = 8'h99;
        @(negedge clk_sys);
        wr_strobe = 1'b0;
        wait_idle(2);

`ifdef PS2_INHIBIT_EN
        wr(1, 8'h5A);
        capture(1, 5, bits, got);
        check("5A reach bit3", 32'(got), 32'd5);
        ps2_clk_in[1] = 1'b0;
        repeat (24) @(negedge clk_sys);
        check("inhibit busy", 32'(busy[1]), 32'd0);
        check("inhibit data", 32'(ps2_data_out[1]), 32'd1);
        check("inhibit byte kept", 32'(fifo_empty[1]), 32'd0);
        ps2_clk_in[1] = 1'b1;
        capture(1, 11, bits, got);
        check("5A resend", 32'(bits), 32'b110_1011_0100);
        wait_idle(1);
`endif

        wr(0, 8'hC3);
        wr(0, 8'h3C);
        capture(0, 4, bits, got);
        check("C3 reach mid", 32'(got), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("midrst clk_out", 32'(ps2_clk_out), 32'b111);
        check("midrst data_out", 32'(ps2_data_out), 32'b111);
        check("midrst empty", 32'(fifo_empty), 32'b111);
        check("midrst busy", 32'(busy), 32'b000);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (200) @(negedge clk_sys);
        check("post rst busy", 32'(busy), 32'b000);
        check("post rst data", 32'(ps2_data_out), 32'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (vectors %0d)", n_vec);
        $fatal(1, "timeout");
    end

endmodule
